dff_share_arbiter: RTL and testbench

Round-robin arbiter that shares a single DATA_W-bit capture register among NREQ requesters using a four-phase req/gnt handshake. A granted requester holds its data stable for HOLD cycles. The block then loads that data into the shared register, pulses ack, and waits for the requester to withdraw before arbitrating again. It is the controller for the lab's storage-register datapath when several sources must write it.

---
 rtl/dff_share_arbiter_if.sv | 18 +
 rtl/dff_share_arbiter.sv | 122 ++++++++++++
 tb/tb_dff_share_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dff_share_arbiter_if.sv
// Requester-side bundle for the shared capture register: req/din in, gnt/ack and captured data out.
interface dff_share_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8
);
   localparam int OWN_W = $clog2(NREQ);

   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] din;
   logic [NREQ-1:0]        gnt;
   logic [NREQ-1:0]        ack;
   logic [DATA_W-1:0]      q;
   logic [OWN_W-1:0]       q_owner;
   logic                   q_valid;

   modport master (output req, din, input gnt, ack, q, q_owner, q_valid);
   modport slave  (input req, din, output gnt, ack, q, q_owner, q_valid);
endinterface

// File: rtl/dff_share_arbiter.sv
// Round-robin owner of one shared capture register; four-phase req/gnt/ack per requester.
// Grant one edge after req, capture+ack HOLD edges later; holds in RELEASE until the owner drops req.
module dff_share_arbiter #(
   parameter int NREQ   = 4,
   parameter int DATA_W = 8,
   parameter int HOLD   = 2
) (
   input  logic               clk,
   input  logic               reset,
   dff_share_arbiter_if.slave bus
);
   localparam int OWN_W = $clog2(NREQ);
   localparam int CNT_W = $clog2(HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t            state, state_nx;
   logic [OWN_W-1:0]  ptr, ptr_nx;
   logic [OWN_W-1:0]  sel, sel_nx;
   logic [OWN_W-1:0]  pick, cand;
   logic [OWN_W-1:0]  q_owner_r, q_owner_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [NREQ-1:0]   gnt_r, gnt_nx;
   logic [NREQ-1:0]   ack_r, ack_nx;
   logic [DATA_W-1:0] q_r, q_nx, slice;
   logic              q_valid_r, q_valid_nx;
   logic              found;

   // Search starts one past the last owner so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand = OWN_W'((int'(ptr) + i) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      slice = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (sel == OWN_W'(k)) slice = bus.din[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_nx   = state;
      ptr_nx     = ptr;
      sel_nx     = sel;
      cnt_nx     = cnt;
      gnt_nx     = '0;
      ack_nx     = '0;
      q_nx       = q_r;
      q_owner_nx = q_owner_r;
      q_valid_nx = q_valid_r;
      case (state)
         IDLE: begin
            if (found) begin
               sel_nx   = pick;
               gnt_nx   = NREQ'(1) << pick;
               cnt_nx   = CNT_W'(HOLD - 1);
               state_nx = GRANT;
            end
         end
         GRANT: begin
            // A withdrawn request wins over capture, even on the final hold cycle.
            if (!bus.req[sel]) begin
               ptr_nx   = sel;
               state_nx = IDLE;
            end else if (cnt != '0) begin
               cnt_nx = cnt - CNT_W'(1);
               gnt_nx = gnt_r;
            end else begin
               q_nx       = slice;
               q_owner_nx = sel;
               q_valid_nx = 1'b1;
               ack_nx     = NREQ'(1) << sel;
               ptr_nx     = sel;
               state_nx   = RELEASE;
            end
         end
         RELEASE: begin
            if (!bus.req[sel]) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= OWN_W'(NREQ - 1);
         sel       <= '0;
         cnt       <= '0;
         gnt_r     <= '0;
         ack_r     <= '0;
         q_r       <= '0;
         q_owner_r <= '0;
         q_valid_r <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         sel       <= sel_nx;
         cnt       <= cnt_nx;
         gnt_r     <= gnt_nx;
         ack_r     <= ack_nx;
         q_r       <= q_nx;
         q_owner_r <= q_owner_nx;
         q_valid_r <= q_valid_nx;
      end
   end

   assign bus.gnt     = gnt_r;
   assign bus.ack     = ack_r;
   assign bus.q       = q_r;
   assign bus.q_owner = q_owner_r;
   assign bus.q_valid = q_valid_r;
endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_dff_share_arbiter;
   localparam int NREQ   = 4;
   localparam int DATA_W = 8;
   localparam int HOLD   = 2;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   // Transaction-level expectations: last owner and the register contents.
   int         last_own;
   logic [7:0] q_exp;
   int         own_exp;
   logic       vld_exp;

   dff_share_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

   dff_share_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .HOLD(HOLD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int rr(input int last, input logic [3:0] m);
      for (int off = 1; off <= NREQ; off++) begin
         int k;
         k = (last + off) % NREQ;
         if (m[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      last_own = NREQ - 1;
      q_exp    = 8'h00;
      own_exp  = 0;
      vld_exp  = 1'b0;
   endtask

   task automatic apply_reset(input logic [3:0] mask);
      bus.req = mask;
      reset   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
   endtask

   // One full request: drive mask/data, follow grant, optional abort, capture and release.
   task automatic transact(input logic [3:0] mask, input logic [31:0] d,
                           input int abort_at, input int drop_delay, output int w);
      logic [3:0] oh;
      bus.req = mask;
      bus.din = d;
      if (mask == 4'b0000) begin
         w = -1;
         @(posedge clk); #1;
         n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL idle_gnt: gnt=%b exp=0000", bus.gnt); end
         return;
      end
      w  = rr(last_own, mask);
      oh = 4'b0001 << w;
      @(posedge clk); #1;
      n_cmp++; if (bus.gnt !== oh) begin n_err++; $display("FAIL grant: gnt=%b exp=%b", bus.gnt, oh); end
      n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL grant_ack: ack=%b exp=0000", bus.ack); end
      for (int c = 1; c <= HOLD; c++) begin
         if (abort_at == c) bus.req[w] = 1'b0;
         @(posedge clk); #1;
         if (abort_at == c) begin
            n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL abort_gnt: gnt=%b exp=0000", bus.gnt); end
            n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL abort_ack: ack=%b exp=0000", bus.ack); end
            n_cmp++; if (bus.q !== q_exp) begin n_err++; $display("FAIL abort_q: q=%h exp=%h", bus.q, q_exp); end
            n_cmp++; if (bus.q_valid !== vld_exp) begin n_err++; $display("FAIL abort_vld: q_valid=%b exp=%b", bus.q_valid, vld_exp); end
            last_own = w;
            return;
         end
         if (c < HOLD) begin
            n_cmp++; if (bus.gnt !== oh) begin n_err++; $display("FAIL hold_gnt: gnt=%b exp=%b", bus.gnt, oh); end
            n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL hold_ack: ack=%b exp=0000", bus.ack); end
         end
      end
      q_exp    = d[w*8 +: 8];
      own_exp  = w;
      vld_exp  = 1'b1;
      last_own = w;
      n_cmp++; if (bus.ack !== oh) begin n_err++; $display("FAIL cap_ack: ack=%b exp=%b", bus.ack, oh); end
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL cap_gnt: gnt=%b exp=0000", bus.gnt); end
      n_cmp++; if (bus.q !== q_exp) begin n_err++; $display("FAIL cap_q: q=%h exp=%h", bus.q, q_exp); end
      n_cmp++; if (bus.q_owner !== 2'(own_exp)) begin n_err++; $display("FAIL cap_owner: q_owner=%0d exp=%0d", bus.q_owner, own_exp); end
      n_cmp++; if (bus.q_valid !== 1'b1) begin n_err++; $display("FAIL cap_vld: q_valid=%b exp=1", bus.q_valid); end
      for (int k = 0; k < drop_delay; k++) begin
         @(posedge clk); #1;
         n_cmp++; if ((bus.gnt | bus.ack) !== 4'b0000) begin n_err++; $display("FAIL release_quiet: gnt=%b ack=%b exp=0000", bus.gnt, bus.ack); end
      end
      bus.req[w] = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if ((bus.gnt | bus.ack) !== 4'b0000) begin n_err++; $display("FAIL release_exit: gnt=%b ack=%b exp=0000", bus.gnt, bus.ack); end
   endtask

   task automatic test_reset();
      int w;
      bus.req = 4'b1111;
      bus.din = '0;
      reset   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: gnt=%b exp=0000", bus.gnt); end
      n_cmp++; if (bus.ack !== 4'b0000) begin n_err++; $display("FAIL rst_ack: ack=%b exp=0000", bus.ack); end
      n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL rst_q: q=%h exp=00", bus.q); end
      n_cmp++; if (bus.q_owner !== 2'd0) begin n_err++; $display("FAIL rst_owner: q_owner=%0d exp=0", bus.q_owner); end
      n_cmp++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL rst_vld: q_valid=%b exp=0", bus.q_valid); end
      reset = 1'b1;
      model_reset();
      transact(4'b1111, 32'h44332211, 0, 0, w);
      n_cmp++; if (bus.q_owner !== 2'd0) begin n_err++; $display("FAIL rst_first_owner: q_owner=%0d exp=0", bus.q_owner); end
   endtask

   task automatic test_single();
      int w;
      transact(4'b0100, 32'h00A50000, 0, 1, w);
      n_cmp++; if (bus.q !== 8'hA5) begin n_err++; $display("FAIL single_q: q=%h exp=a5", bus.q); end
      n_cmp++; if (bus.q_owner !== 2'd2) begin n_err++; $display("FAIL single_owner: q_owner=%0d exp=2", bus.q_owner); end
   endtask

   task automatic test_round_robin();
      int w;
      apply_reset(4'b1111);
      for (int i = 0; i < 6; i++) begin
         transact(4'b1111, 32'h13121110, 0, 0, w);
         n_cmp++; if (bus.q_owner !== 2'(i % 4)) begin n_err++; $display("FAIL rr_owner[%0d]: q_owner=%0d exp=%0d", i, bus.q_owner, i % 4); end
         n_cmp++; if (bus.q !== 8'(16 + i % 4)) begin n_err++; $display("FAIL rr_q[%0d]: q=%h exp=%h", i, bus.q, 8'(16 + i % 4)); end
      end
   endtask

   task automatic test_priority();
      int w;
      transact(4'b0010, $urandom, 0, 0, w);
      transact(4'b0011, $urandom, 0, 0, w);
      n_cmp++; if (bus.q_owner !== 2'd0) begin n_err++; $display("FAIL prio_a: q_owner=%0d exp=0", bus.q_owner); end
      transact(4'b1010, $urandom, 0, 0, w);
      n_cmp++; if (bus.q_owner !== 2'd1) begin n_err++; $display("FAIL prio_b: q_owner=%0d exp=1", bus.q_owner); end
   endtask

   task automatic test_abort();
      int w;
      transact(4'b0100, 32'h00120000, 0, 0, w);
      transact(4'b1001, 32'hEEDDCCBB, 2, 0, w);
      n_cmp++; if (bus.q !== 8'h12) begin n_err++; $display("FAIL abort_keep_q: q=%h exp=12", bus.q); end
      n_cmp++; if (bus.q_owner !== 2'd2) begin n_err++; $display("FAIL abort_keep_owner: q_owner=%0d exp=2", bus.q_owner); end
      transact(4'b0001, 32'h000000C3, 0, 0, w);
      n_cmp++; if (bus.q_owner !== 2'd0) begin n_err++; $display("FAIL abort_next: q_owner=%0d exp=0", bus.q_owner); end
   endtask

   task automatic test_reset_mid();
      int w;
      transact(4'b0001, $urandom, 0, 0, w);
      bus.req = 4'b0010;
      bus.din = 32'h0000_5A00;
      @(posedge clk); #1;
      n_cmp++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL mid_grant: gnt=%b exp=0010", bus.gnt); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL mid_gnt_clear: gnt=%b exp=0000", bus.gnt); end
      n_cmp++; if (bus.q !== 8'h00) begin n_err++; $display("FAIL mid_q: q=%h exp=00", bus.q); end
      n_cmp++; if (bus.q_valid !== 1'b0) begin n_err++; $display("FAIL mid_vld: q_valid=%b exp=0", bus.q_valid); end
      repeat (2) begin
         @(posedge clk); #1;
         n_cmp++; if ((bus.gnt | bus.ack) !== 4'b0000) begin n_err++; $display("FAIL mid_quiet: gnt=%b ack=%b exp=0000", bus.gnt, bus.ack); end
      end
      reset = 1'b1;
      model_reset();
      transact(4'b0010, 32'h0000_5A00, 0, 0, w);
      n_cmp++; if (bus.q_owner !== 2'd1) begin n_err++; $display("FAIL mid_regrant: q_owner=%0d exp=1", bus.q_owner); end
   endtask

   task automatic test_random();
      int w, ab;
      for (int n = 0; n < 150; n++) begin
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HOLD)) : 0;
         transact(4'($urandom_range(0, 15)), $urandom, ab, int'($urandom_range(0, 3)), w);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset   = 1'b0;
      bus.req = '0;
      bus.din = '0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_priority();
      test_abort();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
